// File: rtl/sdr_adc_pkg.sv
// rtl/sdr_adc_pkg.sv - shared widths, limits and sample type for the sigma-delta ADC front end
// Used by the CIC decimator and the PWM output stage.
package sdr_adc_pkg;

  localparam int DEF_DATA_WIDTH = 10;
  localparam int CIC_ORDER_MIN  = 1;
  localparam int CIC_ORDER_MAX  = 5;

  typedef logic signed [DEF_DATA_WIDTH-1:0] sample_t;

  // Register growth of an order-N CIC with decimation 2**decim_log2 and a 1-bit input.
  function automatic int cic_width(input int order, input int decim_log2);
    return order * decim_log2 + 1;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// rtl/cic_comb_stage.sv - one differentiator stage of the CIC comb pipeline
// Output and delay both advance only when en is high; arithmetic wraps mod 2**W.
module cic_comb_stage #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] dly_q;
  logic [W-1:0] out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q <= '0;
      out_q <= '0;
    end else if (en) begin
      out_q <= din - dly_q;
      dly_q <= din;
    end
  end

  assign dout = out_q;

endmodule

// File: rtl/cic_decimator_1bit.sv
// rtl/cic_decimator_1bit.sv - 1-bit sigma-delta front end: comparator sync, feedback, CIC decimation
// Optional DC-removal stage compiled in with `define CIC_DC_BLOCK_EN.
module cic_decimator_1bit
  import sdr_adc_pkg::*;
#(
  parameter int CIC_ORDER  = 3,
  parameter int DECIM_LOG2 = 8,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
`ifdef CIC_DC_BLOCK_EN
  , parameter int DC_SHIFT = 8
`endif
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         CompIn,
  output logic                         SigmaOut,
  output logic signed [DATA_WIDTH-1:0] DataOut,
  output logic                         DataValid
);

  localparam int N = (CIC_ORDER < CIC_ORDER_MIN) ? CIC_ORDER_MIN :
                     (CIC_ORDER > CIC_ORDER_MAX) ? CIC_ORDER_MAX : CIC_ORDER;
  localparam int W = cic_width(N, DECIM_LOG2);

  logic sync1_q, x_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      x_q     <= 1'b0;
    end else begin
      sync1_q <= CompIn;
      x_q     <= sync1_q;
    end
  end

  assign SigmaOut = x_q;

  // Integrators wrap freely; the combs cancel the wrap as long as W covers the gain.
  logic [W-1:0] integ_q [N];
  logic [W-1:0] integ_d [N];

  always_comb begin
    integ_d[0] = integ_q[0] + {{(W-1){1'b0}}, x_q};
    for (int k = 1; k < N; k++) begin
      integ_d[k] = integ_q[k] + integ_q[k-1];
    end
  end

  logic [DECIM_LOG2-1:0] cnt_q;
  logic [N-1:0]          vld_q;
  logic                  decim_tick;

  assign decim_tick = &cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) integ_q[k] <= '0;
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      integ_q <= integ_d;
      cnt_q   <= cnt_q + {{(DECIM_LOG2-1){1'b0}}, 1'b1};
      vld_q   <= (vld_q << 1) | {{(N-1){1'b0}}, decim_tick};
    end
  end

  logic [W-1:0] comb_w [N+1];
  assign comb_w[0] = integ_q[N-1];

  for (genvar k = 0; k < N; k++) begin : g_comb
    logic stage_en;
    if (k == 0) begin : g_first
      assign stage_en = decim_tick;
    end else begin : g_rest
      assign stage_en = vld_q[k-1];
    end
    cic_comb_stage #(.W(W)) u_comb (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (stage_en),
      .din  (comb_w[k]),
      .dout (comb_w[k+1])
    );
  end

  // Only an all-ones input reaches 2**(W-1); clamp it so the offset-binary flip stays positive.
  logic [W-2:0]            sat_w;
  logic [W-DATA_WIDTH-2:0] fmt_lsb_unused;
  logic [DATA_WIDTH-1:0]   f_d;
  logic signed [DATA_WIDTH-1:0] f_q;
  logic                    fvld_q;

  assign sat_w          = comb_w[N][W-1] ? '1 : comb_w[N][W-2:0];
  assign fmt_lsb_unused = sat_w[W-DATA_WIDTH-2:0];
  assign f_d            = {~sat_w[W-2], sat_w[W-3 -: DATA_WIDTH-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q    <= '0;
      fvld_q <= 1'b0;
    end else begin
      fvld_q <= vld_q[N-1];
      if (vld_q[N-1]) f_q <= f_d;
    end
  end

`ifdef CIC_DC_BLOCK_EN
  localparam int AW = DATA_WIDTH + DC_SHIFT + 2;

  logic signed [AW-1:0]           dc_q, dc_d, dc_err;
  logic signed [DATA_WIDTH+1:0]   y_full;
  logic signed [DATA_WIDTH-1:0]   y_sat, out_q;
  logic                           out_vld_q;

  always_comb begin
    dc_err = $signed({{2{f_q[DATA_WIDTH-1]}}, f_q, {DC_SHIFT{1'b0}}}) - dc_q;
    dc_d   = dc_q + (dc_err >>> DC_SHIFT);
    y_full = $signed({{2{f_q[DATA_WIDTH-1]}}, f_q}) - $signed(dc_q[AW-1:DC_SHIFT]);
    if (y_full[DATA_WIDTH+1:DATA_WIDTH-1] == 3'b000 || y_full[DATA_WIDTH+1:DATA_WIDTH-1] == 3'b111) begin
      y_sat = y_full[DATA_WIDTH-1:0];
    end else begin
      y_sat = y_full[DATA_WIDTH+1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc_q      <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      out_vld_q <= fvld_q;
      if (fvld_q) begin
        out_q <= y_sat;
        dc_q  <= dc_d;
      end
    end
  end

  assign DataOut   = out_q;
  assign DataValid = out_vld_q;
`else
  assign DataOut   = f_q;
  assign DataValid = fvld_q;
`endif

endmodule

// File: tb/tb_cic_decimator_1bit.sv
// tb/tb_cic_decimator_1bit.sv - directed self-checking bench for cic_decimator_1bit (default parameters)
// Expected values are hand-derived for CIC_ORDER=3, DECIM_LOG2=8, DATA_WIDTH=10.
module tb_cic_decimator_1bit;

`ifdef CIC_DC_BLOCK_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  // First strobe after release: tick ends at edge 256, then ORDER more edges.
  localparam int FIRST_LAT = 259 + EXTRA;
  localparam int PERIOD    = 256;
  localparam int TICK_LAT  = 4 + EXTRA;

  logic              clk;
  logic              rst_n;
  logic              CompIn;
  logic              SigmaOut;
  logic signed [9:0] DataOut;
  logic              DataValid;

  int       n_assert = 0;
  int       n_fail   = 0;
  logic [3:0] pat = 4'b0000;
  int       ph = 0;

  cic_decimator_1bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .CompIn   (CompIn),
    .SigmaOut (SigmaOut),
    .DataOut  (DataOut),
    .DataValid(DataValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    CompIn = pat[ph];
    ph = (ph + 1) % 4;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!DataValid && n < 600);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ph = 0;
  endtask

  int n;

  initial begin
    rst_n  = 1'b0;
    CompIn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_sigma", int'(SigmaOut), 0);
    check("reset_data", int'(DataOut), 0);
    check("reset_valid", int'(DataValid), 0);

    // Constant 0: full-scale negative
    rst_n = 1'b1;
    wait_valid(n);
    check("zero_first_latency", n, FIRST_LAT);
    for (int s = 2; s <= 6; s++) begin
      wait_valid(n);
      check("zero_period", n, PERIOD);
      if (s >= 4) check("zero_data", int'(DataOut), -512);
    end
    step();
    check("valid_one_cycle", int'(DataValid), 0);

    // Constant 1: saturation path, integrators wrap during this run
    do_reset();
    pat = 4'b1111;
    step();
    step();
    check("sigma_after_1clk", int'(SigmaOut), 0);
    step();
    check("sigma_after_2clk", int'(SigmaOut), 1);
    wait_valid(n);
    for (int s = 2; s <= 10; s++) begin
      wait_valid(n);
      check("one_period", n, PERIOD);
      if (s >= 4) check("one_data", int'(DataOut), 511);
    end

    // 50% density
    do_reset();
    pat = 4'b0101;
    for (int s = 1; s <= 5; s++) begin
      wait_valid(n);
      if (s >= 4) check("half_data", int'(DataOut), 0);
    end

    // 25% density, after the filter memory has flushed
    pat = 4'b0001;
    for (int s = 1; s <= 6; s++) begin
      wait_valid(n);
      if (s >= 5) check("quarter_data", int'(DataOut), -256);
    end

    // Tick-to-strobe latency
    n = 0;
    do begin
      step();
      n++;
    end while (!dut.decim_tick && n < 300);
    check("tick_found", int'(dut.decim_tick), 1);
    wait_valid(n);
    check("tick_to_valid", n, TICK_LAT);

    // Reset 100 clk after that tick
    repeat (96) step();
    rst_n = 1'b0;
    #1;
    check("midreset_data", int'(DataOut), 0);
    check("midreset_valid", int'(DataValid), 0);
    check("midreset_sigma", int'(SigmaOut), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ph = 0;
    wait_valid(n);
    check("midreset_first_latency", n, FIRST_LAT);
    for (int s = 2; s <= 4; s++) begin
      wait_valid(n);
      check("midreset_period", n, PERIOD);
      if (s == 4) check("midreset_data_resume", int'(DataOut), -256);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
